// File: rtl/ppi_bus_sequencer.sv
// ppi_bus_sequencer: host-side master that turns a valid/ready request into
// a timed 8255-style PPI bus cycle (setup, strobe, hold), then returns a
// one-cycle response pulse carrying read data.
// Optional build macro: PPI_CFG_SHADOW_EN adds a cfg_shadow output that
// mirrors mode-set control writes and answers control-register reads locally.
module ppi_bus_sequencer #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [1:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       CS,
  output logic       RD,
  output logic       WR,
  output logic [1:0] A,
  inout  wire  [7:0] D,
  output logic       busy
`ifdef PPI_CFG_SHADOW_EN
  ,
  output logic [7:0] cfg_shadow
`endif
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       write_reg, write_next;
  logic [1:0] addr_reg, addr_next;
  logic [7:0] wdata_reg, wdata_next;
  logic [7:0] rdata_reg, rdata_next;
  logic       cs_reg, cs_next;
  logic       rd_reg, rd_next;
  logic       wr_reg, wr_next;
  logic       d_oe_reg, d_oe_next;
  logic       rsp_valid_reg, rsp_valid_next;
  logic       ready_reg, ready_next;
  logic       busy_reg, busy_next;
  logic       accept;
  logic       in_bus;
`ifdef PPI_CFG_SHADOW_EN
  logic [7:0] shadow_reg, shadow_next;
`endif

  assign accept = req_valid & ready_reg;

  // Next-state, phase counter, latched request and next registered outputs.
  // Outputs are derived from the next state so they line up with the state
  // they belong to, while still coming straight out of flops.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    write_next = write_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
`ifdef PPI_CFG_SHADOW_EN
    shadow_next = shadow_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (accept) begin
          write_next = req_write;
          addr_next  = req_addr;
          wdata_next = req_wdata;
          state_next = SETUP;
          cnt_next   = SETUP_LD;
`ifdef PPI_CFG_SHADOW_EN
          // Mode-set writes (bit 7 set) update the shadow; bit-set/reset
          // writes leave it alone. Control reads are answered locally.
          if (req_write && req_addr == 2'd3 && req_wdata[7])
            shadow_next = req_wdata;
          if (!req_write && req_addr == 2'd3) begin
            state_next = RESP;
            rdata_next = shadow_reg;
          end
`endif
        end
      end
      SETUP: begin
        if (cnt_reg == 4'd0) begin
          state_next = STROBE;
          cnt_next   = STROBE_LD;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      STROBE: begin
        if (cnt_reg == 4'd0) begin
          state_next = HOLD;
          cnt_next   = HOLD_LD;
          // Capture on the edge leaving STROBE, while RD is still low.
          if (!write_reg)
            rdata_next = D;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      HOLD: begin
        if (cnt_reg == 4'd0)
          state_next = RESP;
        else
          cnt_next = cnt_reg - 4'd1;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    in_bus         = (state_next == SETUP) || (state_next == STROBE) || (state_next == HOLD);
    cs_next        = !in_bus;
    rd_next        = !((state_next == STROBE) && !write_next);
    wr_next        = !((state_next == STROBE) && write_next);
    d_oe_next      = in_bus && write_next;
    rsp_valid_next = (state_next == RESP);
    ready_next     = (state_next == IDLE);
    busy_next      = (state_next != IDLE);
  end

  // State and output registers; reset aborts any cycle and releases D.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      write_reg     <= 1'b0;
      addr_reg      <= 2'b00;
      wdata_reg     <= 8'h00;
      rdata_reg     <= 8'h00;
      cs_reg        <= 1'b1;
      rd_reg        <= 1'b1;
      wr_reg        <= 1'b1;
      d_oe_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
      ready_reg     <= 1'b1;
      busy_reg      <= 1'b0;
`ifdef PPI_CFG_SHADOW_EN
      shadow_reg    <= 8'h9B;
`endif
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      write_reg     <= write_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      rdata_reg     <= rdata_next;
      cs_reg        <= cs_next;
      rd_reg        <= rd_next;
      wr_reg        <= wr_next;
      d_oe_reg      <= d_oe_next;
      rsp_valid_reg <= rsp_valid_next;
      ready_reg     <= ready_next;
      busy_reg      <= busy_next;
`ifdef PPI_CFG_SHADOW_EN
      shadow_reg    <= shadow_next;
`endif
    end
  end

  assign D         = d_oe_reg ? wdata_reg : 8'hzz;
  assign A         = addr_reg;
  assign CS        = cs_reg;
  assign RD        = rd_reg;
  assign WR        = wr_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rdata_reg;
  assign req_ready = ready_reg;
  assign busy      = busy_reg;
`ifdef PPI_CFG_SHADOW_EN
  assign cfg_shadow = shadow_reg;
`endif

endmodule
